grf_hazard_ctrl: RTL and testbench
==================================

# grf_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It tracks every in-flight register write in E/M/W with a per-stage Tnew countdown, and stalls the D stage when a source operand cannot be supplied in time. For D-stage register reads it selects the forwarding source: GRF, E or M. The W-stage write-through is handled inside the register file. It also sequences the shared multiply/divide unit with a busy counter, so HI/LO users stall until the unit is free.

## Interface
- `MULT_BUSY`, default 6: number of cycles after a mult/multu issues from D during which `md_busy` is asserted.
- `DIV_BUSY`, default 11: number of cycles after a div/divu issues from D during which `md_busy` is asserted.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `d_rs`, `d_rt`  in  5 each  source register indices of the D-stage instruction.
- `d_rs_tuse`, `d_rt_tuse`  in  2 each  cycles until the operand is consumed. 0 = branch/jr in D; 1 = ALU in E; 2 = store data in M. 3 = operand not used.
- `d_dst`  in  5  destination register of the D instruction.
- `d_write`  in  1  D instruction writes `d_dst`.
- `d_tnew`  in  2  result latency measured on entry to E: 0 = available in E (lui/jal), 1 = ALU or mfhi/mflo, 2 = load.
- `d_md_start`  in  1  D instruction starts the MD unit.
- `d_md_long`  in  1  when starting, the op is a divide.
- `d_md_use`  in  1  D instruction is any MD-unit instruction (mult/div/mfhi/mflo/mthi/mtlo).
- `stall`  out  1  freeze PC and F/D register; insert a bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel`  out  2 each  D-stage read source: 0 = GRF, 1 = E result, 2 = M result.
- `md_busy`  out  1  MD unit occupied.
- `e_tnew`, `m_tnew`  out  2 each  current Tnew of the E and M entries, for the downstream forwarding muxes.

## Operation
- State:
  - Three entries `{dst[4:0], write, tnew[1:0]}` for E, M and W.
  - MD counter `md_cnt[3:0]`.
- Match rule: an entry matches a source register `r` when `write` is 1, `dst == r`, and `r != 0`.
- Priority: for each source, only the youngest matching entry (E over M over W) is considered.
- Operand stall: `stall_rs = (tuse != 3) && match && (entry.tnew > tuse)`. The same rule applies to `rt`.
- W entries always carry tnew 0, so they never cause a stall.
- Forward select, per source:
  - 1 if the youngest match is E with tnew 0.
  - 2 if the youngest match is M with tnew 0.
  - Otherwise 0, covering both a W match and no match.
  - A not-yet-ready non-stalling match also yields 0; the later-stage forwarding muxes cover it.
- MD stall: `d_md_use && md_cnt != 0`.
- Combined stall: `stall = stall_rs | stall_rt | md_stall`. This is combinational from the current state and D inputs.
- Each rising edge, when not in reset:
  - If `stall` = 0, E takes `{d_dst, d_write, d_tnew}`.
  - If `stall` = 1, E takes a bubble `{0, 0, 0}`.
  - M takes E with tnew decremented, saturating at 0.
  - W takes M with tnew forced to 0.
- MD counter, each rising edge:
  - If `!stall && d_md_start`: load `d_md_long ? DIV_BUSY : MULT_BUSY`.
  - Else if `md_cnt != 0`: decrement.
  - `md_busy = (md_cnt != 0)`.
- `e_tnew` and `m_tnew` are direct register outputs.

## Timing
- Reset: on the first edge with `reset` = 1, every entry becomes `{0, 0, 0}` and `md_cnt` becomes 0. After that edge, `stall`, `md_busy`, both `fwd_*_sel`, and `e_tnew`/`m_tnew` are 0.
- A reset during an active MD countdown or during a stall sequence aborts it; there is no residual stall.
- Stall and forward outputs have zero latency (combinational). Pipeline state moves one stage per cycle.
- A load followed by a dependent ALU op costs exactly 1 stall cycle. A load followed by a dependent branch costs 2.
- The E/M/W pipeline advances even while `stall` = 1, so a stall always clears once the producer ages.
- Simultaneous operand and MD stalls produce a single `stall`. Issuing an MD op while `md_cnt` is 1 stalls for one cycle, then issues.
- `d_dst` = 0 with `d_write` = 1 is tracked but can never match, because source register 0 is excluded.
- Tnew saturation: the value 0 remains 0 through M and W.

## Test plan
- Load hazard: `lw $8` (tnew 2) issues, then `addu` with `d_rs` = 8, tuse 1 → `stall` = 1 for exactly one cycle. Next cycle `fwd_rs_sel` = 0 because the M entry has tnew 1; `m_tnew` = 1.
- ALU to branch: `addu $9` (tnew 1), then `beq` with `d_rs` = 9, tuse 0 → 1 stall cycle. On the following cycle `fwd_rs_sel` = 2.
- `lui $10` (tnew 0), then `addu` reading `$10` with tuse 1 → no stall, `fwd_rs_sel` = 1. A `$0` destination and source → no stall, sel 0.
- `div` issues, then `mflo` with `d_md_use` = 1 → `stall` held for 11 cycles; `md_busy` drops and `mflo` issues on the 12th cycle. Same with `mult` → 6 cycles.
- Youngest-match priority: `lw $5`, then `addu $5` (tnew 1), then a reader of `$5` with tuse 1. The E entry, `addu` with tnew 1, governs: no stall, and `fwd_rs_sel` = 0 this cycle.
- Reset mid-operation: assert `reset` during a `div` countdown with a load in E → after that edge `stall` = 0, `md_busy` = 0, `e_tnew` = 0, `m_tnew` = 0.

Source files
------------

// File: rtl/grf_hazard_ctrl_if.sv
// D-stage hazard query bus between decode and the hazard controller.
// Decode drives the operand/dest fields; controller returns stall/forward info.
interface grf_hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic [4:0] d_dst;
  logic       d_write;
  logic [1:0] d_tnew;
  logic       d_md_start;
  logic       d_md_long;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;
  logic [1:0] e_tnew;
  logic [1:0] m_tnew;

  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse,
    output d_dst, d_write, d_tnew,
    output d_md_start, d_md_long, d_md_use,
    input  stall, fwd_rs_sel, fwd_rt_sel,
    input  md_busy, e_tnew, m_tnew
  );

  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse,
    input  d_dst, d_write, d_tnew,
    input  d_md_start, d_md_long, d_md_use,
    output stall, fwd_rs_sel, fwd_rt_sel,
    output md_busy, e_tnew, m_tnew
  );
endinterface

// File: rtl/grf_hazard_ctrl.sv
// Tnew/Tuse hazard controller: E/M/W write tracking, D-stage stall,
// forward-source select and multiply/divide busy sequencing.
module grf_hazard_ctrl #(
  parameter int unsigned MULT_BUSY = 6,
  parameter int unsigned DIV_BUSY  = 11
) (
  input logic              clk,
  input logic              reset,
  grf_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic [4:0] dst;
    logic       write;
    logic [1:0] tnew;
  } ent_t;

  ent_t       e_q;
  ent_t       m_q;
  ent_t       w_q;
  logic [3:0] md_cnt;

  logic       stall_rs;
  logic       stall_rt;
  logic       md_stall;
  logic       stall;
  logic [1:0] m_next_tnew;

  function automatic logic hit(ent_t x, logic [4:0] r);
    return x.write && (x.dst == r) && (r != 5'd0);
  endfunction

  // Youngest match wins; W carries tnew 0 so it can only shadow older
  // nothing and never stall.
  function automatic logic src_stall(
    ent_t e, ent_t m, ent_t w, logic [4:0] r, logic [1:0] tuse
  );
    logic       h;
    logic [1:0] t;
    h = 1'b1;
    t = 2'd0;
    if (hit(e, r))      t = e.tnew;
    else if (hit(m, r)) t = m.tnew;
    else if (hit(w, r)) t = w.tnew;
    else                h = 1'b0;
    return (tuse != 2'd3) && h && (t > tuse);
  endfunction

  function automatic logic [1:0] src_fwd(
    ent_t e, ent_t m, logic [4:0] r
  );
    logic [1:0] s;
    s = 2'd0;
    if (hit(e, r)) begin
      if (e.tnew == 2'd0) s = 2'd1;
    end else if (hit(m, r)) begin
      if (m.tnew == 2'd0) s = 2'd2;
    end
    return s;
  endfunction

  always_comb begin
    stall_rs = src_stall(e_q, m_q, w_q, bus.d_rs, bus.d_rs_tuse);
    stall_rt = src_stall(e_q, m_q, w_q, bus.d_rt, bus.d_rt_tuse);
    md_stall = bus.d_md_use && (md_cnt != 4'd0);
    stall    = stall_rs | stall_rt | md_stall;
  end

  assign m_next_tnew = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;

  assign bus.stall      = stall;
  assign bus.fwd_rs_sel = src_fwd(e_q, m_q, bus.d_rs);
  assign bus.fwd_rt_sel = src_fwd(e_q, m_q, bus.d_rt);
  assign bus.md_busy    = (md_cnt != 4'd0);
  assign bus.e_tnew     = e_q.tnew;
  assign bus.m_tnew     = m_q.tnew;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      md_cnt <= '0;
    end else begin
      if (stall) e_q <= '0;
      else       e_q <= {bus.d_dst, bus.d_write, bus.d_tnew};
      m_q <= {e_q.dst, e_q.write, m_next_tnew};
      w_q <= {m_q.dst, m_q.write, 2'd0};
      if (!stall && bus.d_md_start)
        md_cnt <= bus.d_md_long ? 4'(DIV_BUSY) : 4'(MULT_BUSY);
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Directed bench for grf_hazard_ctrl: load/branch hazards, forwarding,
// MD busy sequencing, youngest-match priority and mid-operation reset.
module tb_grf_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  grf_hazard_ctrl_if bus ();

  grf_hazard_ctrl #(.MULT_BUSY(6), .DIV_BUSY(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [4:0] rs, input logic [1:0] rs_tu,
    input logic [4:0] rt, input logic [1:0] rt_tu,
    input logic [4:0] dst, input logic wr, input logic [1:0] tn,
    input logic st, input logic lg, input logic use_md
  );
    bus.d_rs       = rs;
    bus.d_rs_tuse  = rs_tu;
    bus.d_rt       = rt;
    bus.d_rt_tuse  = rt_tu;
    bus.d_dst      = dst;
    bus.d_write    = wr;
    bus.d_tnew     = tn;
    bus.d_md_start = st;
    bus.d_md_long  = lg;
    bus.d_md_use   = use_md;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_stall", {3'd0, bus.stall}, 4'd0);
    chk("rst_busy", {3'd0, bus.md_busy}, 4'd0);
    chk("rst_fwd_rs", {2'd0, bus.fwd_rs_sel}, 4'd0);
    chk("rst_fwd_rt", {2'd0, bus.fwd_rt_sel}, 4'd0);
    chk("rst_e_tnew", {2'd0, bus.e_tnew}, 4'd0);
    chk("rst_m_tnew", {2'd0, bus.m_tnew}, 4'd0);

    // lw $8 then dependent addu
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("lw_nostall", {3'd0, bus.stall}, 4'd0);
    step();
    drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd11, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("load_stall", {3'd0, bus.stall}, 4'd1);
    chk("load_e_tnew", {2'd0, bus.e_tnew}, 4'd2);
    step();
    chk("load_clear", {3'd0, bus.stall}, 4'd0);
    chk("load_fwd", {2'd0, bus.fwd_rs_sel}, 4'd0);
    chk("load_m_tnew", {2'd0, bus.m_tnew}, 4'd1);
    chk("bubble_e", {2'd0, bus.e_tnew}, 4'd0);
    step();
    drain();

    // addu $9 then beq reading $9 on rs (tuse 0) and rt (tuse 1)
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd9, 2'd0, 5'd9, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("br_stall", {3'd0, bus.stall}, 4'd1);
    step();
    chk("br_clear", {3'd0, bus.stall}, 4'd0);
    chk("br_fwd_rs", {2'd0, bus.fwd_rs_sel}, 4'd2);
    chk("br_fwd_rt", {2'd0, bus.fwd_rt_sel}, 4'd2);
    step();
    drain();

    // lui $10 then addu reading $10 and $0
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd10, 2'd1, 5'd0, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("lui_nostall", {3'd0, bus.stall}, 4'd0);
    chk("lui_fwd_rs", {2'd0, bus.fwd_rs_sel}, 4'd1);
    chk("lui_fwd_rt0", {2'd0, bus.fwd_rt_sel}, 4'd0);
    step();
    chk("lui_m_sat", {2'd0, bus.m_tnew}, 4'd0);
    drain();

    // $0 destination never matches
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("zero_nostall", {3'd0, bus.stall}, 4'd0);
    chk("zero_fwd", {2'd0, bus.fwd_rs_sel}, 4'd0);
    drain();

    // div then mflo: 11 stall cycles
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    step();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    chk("div_busy", {3'd0, bus.md_busy}, 4'd1);
    for (int i = 0; i < 11; i++) begin
      chk("div_stall", {3'd0, bus.stall}, 4'd1);
      step();
    end
    chk("div_release", {3'd0, bus.stall}, 4'd0);
    chk("div_idle", {3'd0, bus.md_busy}, 4'd0);
    step();
    drain();

    // mult then mflo: 6 stall cycles
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    step();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("mult_stall", {3'd0, bus.stall}, 4'd1);
      step();
    end
    chk("mult_release", {3'd0, bus.stall}, 4'd0);
    step();
    drain();

    // mult issued while md_cnt is 1: one stall then issue
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    step();
    idle();
    repeat (5) step();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("md_cnt1_stall", {3'd0, bus.stall}, 4'd1);
    step();
    chk("md_cnt1_issue", {3'd0, bus.stall}, 4'd0);
    step();
    chk("md_reissue_busy", {3'd0, bus.md_busy}, 4'd1);
    idle();
    repeat (7) step();

    // youngest-match priority: lw $5, addu $5, reader of $5
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("young_nostall", {3'd0, bus.stall}, 4'd0);
    chk("young_fwd", {2'd0, bus.fwd_rs_sel}, 4'd0);
    drain();

    // reset during a div countdown with a load in E
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    step();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd8, 2'd0, 5'd0, 2'd3, 5'd12, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_stall", {3'd0, bus.stall}, 4'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_stall", {3'd0, bus.stall}, 4'd0);
    chk("mid_rst_busy", {3'd0, bus.md_busy}, 4'd0);
    chk("mid_rst_e", {2'd0, bus.e_tnew}, 4'd0);
    chk("mid_rst_m", {2'd0, bus.m_tnew}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
